// File: rtl/lifo_fifo_buffer.sv
// lifo_fifo_buffer: buffer with its own storage that runs as a stack (LIFO)
// or a queue (FIFO). The mode is latched only while the buffer is empty.
// Provides a show-ahead head word, occupancy flags and sticky error flags.
module lifo_fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_TH      = 2**ADDR_WIDTH-2,
  parameter int AE_TH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_tmp,
  input  logic                  mode_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  mode_active
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   AF_C     = (ADDR_WIDTH+1)'(AF_TH);
  localparam logic [ADDR_WIDTH:0]   AE_C     = (ADDR_WIDTH+1)'(AE_TH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  mode_q, mode_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] head;
  logic                  is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);

  // Next-state: pointer/count moves, storage write strobe, mode latch and sticky errors
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mode_d   = mode_q;
    ovf_d    = clr_err ? 1'b0 : ovf_q;
    udf_d    = clr_err ? 1'b0 : udf_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    // While empty the mode may change, and the FIFO read pointer is pinned to
    // the write pointer so a LIFO->FIFO switch finds the first word at rd_ptr.
    if (is_empty) begin
      mode_d   = mode_in;
      rd_ptr_d = wr_ptr_q;
    end
    unique case ({push, pop})
      2'b11: begin
        if (is_empty) begin
          // pop rejected, push accepted
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = CNT_ONE;
          udf_d    = 1'b1;
        end else if (mode_q) begin
          // LIFO: overwrite the top of stack in place
          we    = 1'b1;
          waddr = wr_ptr_q - PTR_ONE;
        end else begin
          // FIFO: drop head, append new word; occupancy unchanged
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end
      2'b10: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (is_empty) begin
          udf_d = 1'b1;
        end else begin
          count_d = count_q - CNT_ONE;
          if (mode_q) wr_ptr_d = wr_ptr_q - PTR_ONE;
          else        rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end
      default: ;
    endcase
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge reset_tmp) begin
    if (reset_tmp) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mode_q   <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array: no reset, contents become unreachable once count is cleared
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wr_data;
  end

  // Show-ahead head word and flags decoded from the registered count
  assign head         = mode_q ? (wr_ptr_q - PTR_ONE) : rd_ptr_q;
  assign rd_data      = is_empty ? '0 : mem_q[head];
  assign count        = count_q;
  assign empty        = is_empty;
  assign full         = is_full;
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign mode_active  = mode_q;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Scoreboard bench for lifo_fifo_buffer: a queue-based reference model
// produces expected outputs per cycle; a monitor compares at each negedge.
module tb_lifo_fifo_buffer;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset_tmp = 1'b1;
  logic          mode_in = 1'b1, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          empty, full, almost_empty, almost_full, overflow, underflow, mode_active;

  typedef struct packed {
    logic [DW-1:0] rd;
    logic [AW:0]   cnt;
    logic          emp, ful, ae, af, ovf, udf, md;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic          m_mode = 1'b1, m_ovf = 1'b0, m_udf = 1'b0;

  lifo_fifo_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_TH(AF), .AE_TH(AE)) dut (
    .clk(clk), .reset_tmp(reset_tmp), .mode_in(mode_in), .push(push), .pop(pop),
    .wr_data(wr_data), .clr_err(clr_err), .rd_data(rd_data), .count(count),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow), .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample_dut();
    obs_t o;
    o = '{rd_data, count, empty, full, almost_empty, almost_full, overflow, underflow, mode_active};
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    int n;
    n     = mq.size();
    o.rd  = (n == 0) ? '0 : (m_mode ? mq[n-1] : mq[0]);
    o.cnt = (AW+1)'(n);
    o.emp = (n == 0);
    o.ful = (n == DEPTH);
    o.ae  = (n <= AE);
    o.af  = (n >= AF);
    o.ovf = m_ovf;
    o.udf = m_udf;
    o.md  = m_mode;
    return o;
  endfunction

  function automatic void model_step(input logic pu, input logic po, input logic [DW-1:0] d,
                                     input logic m, input logic ce);
    int  n;
    logic eo, eu;
    logic [DW-1:0] tmp;
    n  = mq.size();
    eo = 1'b0;
    eu = 1'b0;
    if (pu && po) begin
      if (n == 0) begin
        mq.push_back(d);
        eu = 1'b1;
      end else if (m_mode) begin
        tmp = mq.pop_back();
        mq.push_back(d);
      end else begin
        tmp = mq.pop_front();
        mq.push_back(d);
      end
    end else if (pu) begin
      if (n == DEPTH) eo = 1'b1;
      else            mq.push_back(d);
    end else if (po) begin
      if (n == 0)       eu = 1'b1;
      else if (m_mode)  tmp = mq.pop_back();
      else              tmp = mq.pop_front();
    end
    if (ce) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (eo) m_ovf = 1'b1;
    if (eu) m_udf = 1'b1;
    if (n == 0) m_mode = m;
  endfunction

  task automatic step(input logic pu, input logic po, input logic [DW-1:0] d,
                      input logic m, input logic ce);
    @(negedge clk);
    push = pu; pop = po; wr_data = d; mode_in = m; clr_err = ce;
    @(posedge clk);
    model_step(pu, po, d, m, ce);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input logic m);
    step(1'b0, 1'b0, '0, m, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs are checked before any edge.
  task automatic apply_reset();
    obs_t g, e;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    #2 reset_tmp = 1'b1;
    mq.delete();
    m_mode = 1'b1; m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    g = sample_dut();
    e = model_obs();
    vectors++;
    if (g !== e) begin
      errors++;
      $display("FAIL reset_async: got rd=%h cnt=%0d emp=%b ful=%b ae=%b af=%b ovf=%b udf=%b md=%b, want rd=%h cnt=%0d emp=%b ful=%b ae=%b af=%b ovf=%b udf=%b md=%b",
               g.rd, g.cnt, g.emp, g.ful, g.ae, g.af, g.ovf, g.udf, g.md,
               e.rd, e.cnt, e.emp, e.ful, e.ae, e.af, e.ovf, e.udf, e.md);
    end
    @(negedge clk);
    reset_tmp = 1'b0;
  endtask

  // Monitor: one expected observation per cycle, compared away from the active edge
  initial begin
    obs_t g, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = sample_dut();
        vectors++;
        if (g !== e) begin
          errors++;
          $display("FAIL out@%0t: got rd=%h cnt=%0d emp=%b ful=%b ae=%b af=%b ovf=%b udf=%b md=%b, want rd=%h cnt=%0d emp=%b ful=%b ae=%b af=%b ovf=%b udf=%b md=%b",
                   $time, g.rd, g.cnt, g.emp, g.ful, g.ae, g.af, g.ovf, g.udf, g.md,
                   e.rd, e.cnt, e.emp, e.ful, e.ae, e.af, e.ovf, e.udf, e.md);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic pu, po, m, ce;
    int   pp;
    // power-up reset
    apply_reset();

    // LIFO basics: push 11,22,33 then pop back out, then pop empty
    step(1, 0, 8'h11, 1, 0);
    step(1, 0, 8'h22, 1, 0);
    step(1, 0, 8'h33, 1, 0);
    repeat (3) step(0, 1, '0, 1, 0);
    step(0, 1, '0, 1, 0);            // underflow
    step(0, 0, '0, 1, 1);            // clear

    // FIFO fill A0..AF, mode_in toggles once non-empty
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'hA0 + DW'(i), (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 0);
    step(1, 0, 8'hFF, 1, 0);         // overflow, dropped
    step(0, 0, '0, 1, 1);            // clear overflow
    step(1, 1, 8'h5A, 1, 0);         // full FIFO push&pop
    for (int i = 0; i < DEPTH; i++) step(0, 1, '0, 1'($urandom_range(0, 1)), 0);

    // LIFO replace-in-place
    step(1, 0, 8'h11, 1, 0);
    step(1, 0, 8'h22, 1, 0);
    step(1, 1, 8'h99, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 1, '0, 0, 0);

    // FIFO wrap at count 5, then empty push&pop
    for (int i = 0; i < 5; i++) step(1, 0, DW'(8'h40 + i), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, DW'($urandom), 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, '0, 0, 0);
    step(1, 1, 8'h77, 0, 0);
    step(0, 1, '0, 1, 1);

    // randomized phases with drifting push/pop bias
    for (int ph = 0; ph < 8; ph++) begin
      pp = (ph % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 80; i++) begin
        pu = ($urandom_range(0, 99) < pp);
        po = ($urandom_range(0, 99) < 100 - pp);
        m  = 1'($urandom_range(0, 1));
        ce = ($urandom_range(0, 15) == 0);
        step(pu, po, DW'($urandom), m, ce);
      end
    end

    // reset mid-burst with count=7 in FIFO mode and underflow set
    while (mq.size() != 0) step(0, 1, '0, 0, 0);
    step(0, 1, '0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, DW'(8'hC0 + i), 0, 0);
    apply_reset();
    step(1, 0, 8'h5E, 1, 0);
    step(1, 0, 8'h6F, 1, 0);
    step(0, 1, '0, 1, 0);
    step(0, 1, '0, 1, 0);
    idle(1);

    // drain scoreboard with a bounded wait
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected observations never compared, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lifo_fifo_buffer.md
# lifo_fifo_buffer

Parametrised stack/queue buffer with integrated storage, occupancy tracking and sticky error flags. It replaces the bare pointer controller: one block now holds the data array, runs as a LIFO or a FIFO (the mode is latched only while empty), and gives a show-ahead read port. It sits between a producer issuing push/wr_data and a consumer sampling rd_data and issuing pop.

## Interface
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 4, depth = 2**ADDR_WIDTH words
- AF_TH, 2**ADDR_WIDTH-2, almost_full asserted when count >= AF_TH
- AE_TH, 2, almost_empty asserted when count <= AE_TH

- clk  in  1  clock, rising edge
- reset_tmp  in  1  asynchronous, active-high reset
- mode_in  in  1  requested mode: 1 = LIFO, 0 = FIFO
- push  in  1  write request
- pop  in  1  read/remove request
- wr_data  in  DATA_WIDTH  word written on an accepted push
- clr_err  in  1  synchronous clear of overflow/underflow
- rd_data  out  DATA_WIDTH  head word (LIFO: top of stack; FIFO: oldest word); 0 when empty
- count  out  ADDR_WIDTH+1  number of stored words, 0..2**ADDR_WIDTH
- empty, full  out  1  count==0 / count==2**ADDR_WIDTH
- almost_empty, almost_full  out  1  threshold flags per parameters
- overflow, underflow  out  1  sticky error flags
- mode_active  out  1  mode currently in force

## Operation
- State: storage array (not reset), wr_ptr and rd_ptr (ADDR_WIDTH bits, modulo-2**ADDR_WIDTH wrap), count, mode_active, overflow, underflow.
- Head address: LIFO = wr_ptr-1 (mod depth); FIFO = rd_ptr. rd_data = storage[head] when count!=0, else 0.
- Push accepted (not full, or full with pop): storage[wr_ptr] <= wr_data.
- LIFO push only: wr_ptr+1, count+1. LIFO pop only: wr_ptr-1, count-1. rd_ptr is unused in LIFO.
- FIFO push only: wr_ptr+1, count+1. FIFO pop only: rd_ptr+1, count-1.
- push & pop, non-empty, LIFO: the top word is replaced in place (storage[wr_ptr-1] <= wr_data). Pointers and count are unchanged.
- push & pop, non-empty, FIFO (including full): the head is removed and wr_data is appended. wr_ptr+1, rd_ptr+1, count unchanged.
- push & pop, empty: the push is accepted and the pop is rejected. underflow is set and count becomes 1.
- Push only while full: the word is dropped, overflow is set, and state is otherwise unchanged.
- Pop only while empty: underflow is set and state is otherwise unchanged.
- Mode change:
  - mode_active <= mode_in on any edge where count==0 at the start of the cycle.
  - Any push in that cycle lands at wr_ptr, which is identical for both modes.
  - While count!=0, mode_in is ignored.
- When count==0 in the next state in FIFO mode, rd_ptr is kept equal to wr_ptr (true by construction).
- clr_err clears both sticky flags. If an error occurs in the same cycle, setting wins over clear.

## Timing
- Reset (asynchronous, immediate):
  - wr_ptr = rd_ptr = 0, count = 0, mode_active = 1 (LIFO).
  - Outputs: empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, rd_data = 0.
- Reset mid-operation discards all contents. Storage values persist but are unreachable.
- Single clock domain. All state updates on the rising edge.
- Flags are decoded combinationally from the registered count; there are no extra flag registers.
- Write-to-read latency: a word pushed at edge N is visible on rd_data after edge N (same cycle that empty falls).
- Pop latency: the next head appears on rd_data immediately after the edge that accepts the pop.
- No handshake stalls: requests are single-cycle strobes, sampled every edge. Throughput is one push and/or one pop per cycle.
- count never exceeds 2**ADDR_WIDTH and never goes below 0. Pointer wrap is modulo depth with no extra bit.

## Test plan
- Reset, LIFO default, push 0x11,0x22,0x33 -> count=3, rd_data=0x33. Pops return 0x33,0x22,0x11, then empty=1 and rd_data=0.
- Empty, mode_in=0, push 0xA0..0xAF (16 words, depth 16) -> full=1, almost_full from count=14. Pops return 0xA0 first. mode_in toggling while non-empty leaves mode_active=0.
- Full FIFO, push 0xFF only -> overflow=1, count stays 16, 0xFF is never read. clr_err -> overflow=0.
- LIFO with count=2 (top 0x22), push&pop with wr_data 0x99 -> count=2, rd_data=0x99. A following pop exposes the older word 0x11.
- FIFO wrap: 40 cycles of interleaved push&pop at count=5 -> count stays 5, data order preserved across pointer wrap. Empty push&pop -> count=1, underflow=1.
- Assert reset_tmp mid-burst with count=7 -> count, empty and all flags take reset values within the same cycle. Next push/pop behaves as from power-up.
